// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with a valid/ready handshake.
//   SKID_EN=1 gives a 2-entry skid buffer, so in_ready depends only on local
//   state and flush. SKID_EN=0 gives a single register.
// Ports: clk, rst (sync, active-high), flush,
//   in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data
//   (downstream), occupancy (entries held), stall_cnt (saturating count of
//   stalled cycles).
module pipe_skid_reg #(
  parameter int unsigned DATA_W         = 32,
  parameter bit          SKID_EN        = 1'b1,
  parameter bit          FLUSH_CLR_DATA = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding equals the entry count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;

  // Skid mode: ready comes from registered state only, breaking the stall path.
  assign in_ready = ~flush & (SKID_EN ? (state != TWO) : (~out_valid | out_ready));

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      stall_cnt <= '0;
      if (FLUSH_CLR_DATA) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      if (flush) begin
        state <= EMPTY;
        if (FLUSH_CLR_DATA) begin
          main_q <= '0;
          skid_q <= '0;
        end
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_q <= in_data;
              state  <= ONE;
            end
          end
          ONE: begin
            // Without the skid entry, in_fire while ONE implies out_fire.
            if (in_fire && (out_fire || !SKID_EN)) begin
              main_q <= in_data;
            end else if (in_fire) begin
              skid_q <= in_data;
              state  <= TWO;
            end else if (out_fire) begin
              state  <= EMPTY;
            end
          end
          TWO: begin
            if (out_fire) begin
              main_q <= skid_q;
              state  <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed-field stage registers between pipeline stages (EXE->MEM and similar).
- Carries one packed payload of DATA_W bits with a valid/ready handshake instead of a bare write-enable.
- A 2-entry skid buffer makes in_ready depend only on local state, which breaks the stall path between stages.
- Adds synchronous flush with optional data clearing, an occupancy output, and a saturating back-pressure counter. It is instantiated once per stage boundary.

Parameters:
- DATA_W, 32, payload width in bits (>=1).
- SKID_EN, 1, 1 = 2-entry skid mode; 0 = single-register mode.
- FLUSH_CLR_DATA, 1, 1 = flush/reset also zero the data registers; 0 = flush/reset clear valid bits only.
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  downstream payload; always equals the main register.
- occupancy  out  2  number of entries held (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values (next edge after rst=1):
  - out_valid=0, occupancy=0, stall_cnt=0, internal skid valid=0.
  - main and skid data = 0 when FLUSH_CLR_DATA=1; unchanged otherwise.
  - rst has priority over flush and over any handshake.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Data is forwarded strictly in order; no beat is duplicated or dropped except by flush or rst.
- SKID_EN=1 state machine (EMPTY / ONE / TWO):
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE, in_fire & out_fire -> ONE, main <= in_data.
  - ONE, in_fire & !out_fire -> TWO, skid <= in_data.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, otherwise -> hold.
  - TWO: out_fire -> ONE, main <= skid. in_fire cannot occur in TWO.
  - in_ready = (state != TWO) & ~flush. The state term is registered; flush gates it combinationally.
  - out_valid = (state != EMPTY).
- SKID_EN=0: single register.
  - in_ready = (~out_valid | out_ready) & ~flush.
  - in_fire loads main and sets out_valid.
  - out_fire without in_fire clears out_valid.
  - occupancy never exceeds 1.
- Latency: a beat accepted at edge N appears on out_data/out_valid at cycle N+1. There is no combinational in->out path in either mode.
- Flush (flush=1 at an edge, rst=0):
  - State -> EMPTY, out_valid=0, occupancy=0.
  - Data registers are zeroed only if FLUSH_CLR_DATA=1.
  - A beat presented during flush is not accepted, because in_ready=0.
  - out_fire may still be seen downstream that cycle; the flush discards the stage's contents regardless.
  - stall_cnt is not cleared by flush.
- stall_cnt:
  - Increments by 1 on each edge where out_valid & ~out_ready & ~flush.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - Cleared only by rst.
- occupancy equals the number of valid entries after each edge: EMPTY=0, ONE=1, TWO=2.
- Out-of-protocol input: in_valid/in_data may change while in_ready=0 without effect.

Test Plan:
- Streaming: SKID_EN=1, out_ready=1, in_valid=1, data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each; occupancy stays 1; in_ready stays 1; stall_cnt=0.
- Back-pressure: after 0xA is accepted, drop out_ready. Offer 0xB -> accepted into skid, occupancy=2, in_ready=0 next cycle; 0xC is held upstream. Raise out_ready -> outputs 0xA,0xB,0xC in order; stall_cnt equals the number of low-out_ready cycles with out_valid=1.
- Flush while full: occupancy=2 holding 0x11,0x22, pulse flush with in_valid=1, in_data=0x33 -> next cycle out_valid=0, occupancy=0, out_data=0 (FLUSH_CLR_DATA=1); 0x33 is not accepted; stall_cnt is unchanged.
- Reset mid-operation: occupancy=2, assert rst together with flush and in_valid -> next cycle all outputs are 0, including stall_cnt. With FLUSH_CLR_DATA=0, out_data keeps its old value but out_valid=0.
- Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reads 15 and stays at 15.
- Single-register mode: SKID_EN=0, out_ready=0 while valid -> in_ready=0 and occupancy=1. Then out_ready=1 with in_valid=1, data 0x5 -> 0x5 is accepted the same cycle the old beat leaves; occupancy stays 1.
